// File: rtl/sdram_initialize.sv
`default_nettype none
// ============================================================================
// sdram_initialize : JEDEC power-up sequencer for a 16-bit SDR SDRAM
// Rev 1.0
// ============================================================================
module sdram_initialize #(
  parameter int          INIT_WAIT_CYCLES = 20000,
  parameter int          TRP_CYCLES       = 3,
  parameter int          TRFC_CYCLES      = 7,
  parameter int          TMRD_CYCLES      = 2,
  parameter int          REFRESH_COUNT    = 8,
  parameter logic [12:0] MODE_REG         = 13'b0000000110011
) (
  input  logic        iclk,
  input  logic        ireset,
  input  logic        ireq,
  input  logic        ienb,
  output logic        ofin,
  output logic [12:0] DRAM_ADDR,
  output logic [1:0]  DRAM_BA,
  output logic        DRAM_CAS_N,
  output logic        DRAM_CKE,
  output logic        DRAM_CLK,
  output logic        DRAM_CS_N,
  inout  wire  [15:0] DRAM_DQ,
  output logic        DRAM_LDQM,
  output logic        DRAM_RAS_N,
  output logic        DRAM_UDQM,
  output logic        DRAM_WE_N
);

  localparam int MAX_A = (INIT_WAIT_CYCLES > TRP_CYCLES) ? INIT_WAIT_CYCLES : TRP_CYCLES;
  localparam int MAX_B = (TRFC_CYCLES > TMRD_CYCLES) ? TRFC_CYCLES : TMRD_CYCLES;
  localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CNT_W = $clog2(MAX_C + 1);
  localparam int REF_W = $clog2(REFRESH_COUNT + 1);

  localparam logic [3:0] c_CMD_NOP  = 4'b0111;
  localparam logic [3:0] c_CMD_PRE  = 4'b0010;
  localparam logic [3:0] c_CMD_AREF = 4'b0001;
  localparam logic [3:0] c_CMD_LMR  = 4'b0000;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_PRE  = 3'd2,
    S_REF  = 3'd3,
    S_LMR  = 3'd4,
    S_DONE = 3'd5
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [REF_W-1:0]   ref_q, ref_d;
  logic [3:0]         cmd_q, cmd_d;
  logic [12:0]        addr_q, addr_d;
  logic [1:0]         ba_q, ba_d;
  logic               cke_q, cke_d;
  logic               fin_q, fin_d;

  always_ff @(posedge iclk) begin
    if (!ireset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ref_q   <= '0;
      cmd_q   <= c_CMD_NOP;
      addr_q  <= '0;
      ba_q    <= '0;
      cke_q   <= 1'b0;
      fin_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ref_q   <= ref_d;
      cmd_q   <= cmd_d;
      addr_q  <= addr_d;
      ba_q    <= ba_d;
      cke_q   <= cke_d;
      fin_q   <= fin_d;
    end
  end

  // Outputs are computed for the cycle after the edge, so each command
  // appears on the pins in the first cycle of its state.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ref_d   = ref_q;
    cmd_d   = c_CMD_NOP;
    addr_d  = '0;
    ba_d    = '0;
    cke_d   = 1'b1;
    fin_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        cke_d = 1'b0;
        cnt_d = '0;
        ref_d = '0;
        if (ireq) begin
          state_d = S_WAIT;
          cke_d   = 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == CNT_W'(INIT_WAIT_CYCLES - 1)) begin
          state_d = S_PRE;
          cnt_d   = '0;
          cmd_d   = c_CMD_PRE;
          addr_d  = 13'h0400;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_PRE: begin
        if (cnt_q == CNT_W'(TRP_CYCLES - 1)) begin
          state_d = S_REF;
          cnt_d   = '0;
          ref_d   = '0;
          cmd_d   = c_CMD_AREF;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_REF: begin
        if (cnt_q == CNT_W'(TRFC_CYCLES - 1)) begin
          cnt_d = '0;
          if (ref_q == REF_W'(REFRESH_COUNT - 1)) begin
            state_d = S_LMR;
            cmd_d   = c_CMD_LMR;
            addr_d  = MODE_REG;
          end else begin
            ref_d = ref_q + 1'b1;
            cmd_d = c_CMD_AREF;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_LMR: begin
        if (cnt_q == CNT_W'(TMRD_CYCLES - 1)) begin
          state_d = S_DONE;
          cnt_d   = '0;
          fin_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        fin_d = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
        cke_d   = 1'b0;
      end
    endcase
  end

  assign ofin       = fin_q;
  assign DRAM_CS_N  = ienb ? cmd_q[3] : 1'bz;
  assign DRAM_RAS_N = ienb ? cmd_q[2] : 1'bz;
  assign DRAM_CAS_N = ienb ? cmd_q[1] : 1'bz;
  assign DRAM_WE_N  = ienb ? cmd_q[0] : 1'bz;
  assign DRAM_ADDR  = ienb ? addr_q   : {13{1'bz}};
  assign DRAM_BA    = ienb ? ba_q     : 2'bzz;
  assign DRAM_CKE   = ienb ? cke_q    : 1'bz;
  assign DRAM_CLK   = ienb ? ~iclk    : 1'bz;
  assign DRAM_LDQM  = ienb ? 1'b1     : 1'bz;
  assign DRAM_UDQM  = ienb ? 1'b1     : 1'bz;
  assign DRAM_DQ    = {16{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_sdram_initialize.sv
`default_nettype none
// tb_sdram_initialize : directed checks of the SDRAM init sequencer, small
// timing set on one instance and default timing on a second.
module tb_sdram_initialize;

  logic clk = 1'b0;
  logic ireset = 1'b0, ireq = 1'b0, ienb = 1'b1;
  logic ireset2 = 1'b0, ireq2 = 1'b0;

  wire        fin, cas_n, cke, dclk, cs_n, ldqm, ras_n, udqm, we_n;
  wire [12:0] addr;
  wire [1:0]  ba;
  wire [15:0] dq;

  wire        fin2, cas_n2, cke2, dclk2, cs_n2, ldqm2, ras_n2, udqm2, we_n2;
  wire [12:0] addr2;
  wire [1:0]  ba2;
  wire [15:0] dq2;

  // Pulls opposite to each pin's driven value make a released pin visible.
  pullup   (addr);
  pullup   (ba);
  pullup   (cs_n);
  pullup   (ras_n);
  pullup   (cas_n);
  pullup   (we_n);
  pulldown (cke);
  pulldown (dclk);
  pulldown (ldqm);
  pulldown (udqm);
  pullup   (dq);
  pullup   (dq2);

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  sdram_initialize #(
    .INIT_WAIT_CYCLES(10), .TRP_CYCLES(2), .TRFC_CYCLES(4),
    .TMRD_CYCLES(2), .REFRESH_COUNT(2)
  ) u_dut (
    .iclk(clk), .ireset(ireset), .ireq(ireq), .ienb(ienb), .ofin(fin),
    .DRAM_ADDR(addr), .DRAM_BA(ba), .DRAM_CAS_N(cas_n), .DRAM_CKE(cke),
    .DRAM_CLK(dclk), .DRAM_CS_N(cs_n), .DRAM_DQ(dq), .DRAM_LDQM(ldqm),
    .DRAM_RAS_N(ras_n), .DRAM_UDQM(udqm), .DRAM_WE_N(we_n)
  );

  sdram_initialize u_dut_def (
    .iclk(clk), .ireset(ireset2), .ireq(ireq2), .ienb(1'b1), .ofin(fin2),
    .DRAM_ADDR(addr2), .DRAM_BA(ba2), .DRAM_CAS_N(cas_n2), .DRAM_CKE(cke2),
    .DRAM_CLK(dclk2), .DRAM_CS_N(cs_n2), .DRAM_DQ(dq2), .DRAM_LDQM(ldqm2),
    .DRAM_RAS_N(ras_n2), .DRAM_UDQM(udqm2), .DRAM_WE_N(we_n2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    ireset = 1'b0;
    ireq   = 1'b0;
    repeat (3) cyc();
    ireset = 1'b1;
  endtask

  // Pulse ireq now (edge E is the next rising edge) and check cycles E+1..E+n.
  task automatic trace(input string tag, input int n, input bit hiz, input bit extra);
    logic [3:0]  cmd_e;
    logic [12:0] addr_e;
    ireq = 1'b1;
    for (int k = 1; k <= n; k++) begin
      cyc();
      ireq = extra && (k == 3 || k == 6);
      cmd_e  = (k == 11) ? 4'b0010 : (k == 13 || k == 17) ? 4'b0001 :
               (k == 21) ? 4'b0000 : 4'b0111;
      addr_e = (k == 11) ? 13'h0400 : (k == 21) ? 13'h0033 : 13'h0000;
      check($sformatf("%s_c%0d_fin", tag, k), {31'd0, fin}, {31'd0, k >= 23});
      check($sformatf("%s_c%0d_dq", tag, k), {16'd0, dq}, 32'h0000_FFFF);
      if (hiz) begin
        check($sformatf("%s_c%0d_cmd", tag, k), {28'd0, cs_n, ras_n, cas_n, we_n}, 32'hF);
        check($sformatf("%s_c%0d_addr", tag, k), {19'd0, addr}, 32'h1FFF);
        check($sformatf("%s_c%0d_pins", tag, k), {26'd0, ba, cke, ldqm, udqm, dclk}, 32'h30);
      end else begin
        check($sformatf("%s_c%0d_cmd", tag, k), {28'd0, cs_n, ras_n, cas_n, we_n}, {28'd0, cmd_e});
        check($sformatf("%s_c%0d_addr", tag, k), {19'd0, addr}, {19'd0, addr_e});
        check($sformatf("%s_c%0d_pins", tag, k), {26'd0, ba, cke, ldqm, udqm, dclk}, 32'h0F);
      end
    end
  endtask

  initial begin
    int nref, pre_k, lmr_k, fin_k;
    bit dq_bad;

    // Idle after reset: no request, nothing starts.
    do_reset();
    for (int k = 0; k < 50; k++) begin
      cyc();
      check("idle_cke_fin", {30'd0, cke, fin}, 32'h0);
      check("idle_cmd", {28'd0, cs_n, ras_n, cas_n, we_n}, 32'h7);
      check("idle_addr_ba", {17'd0, addr, ba}, 32'h0);
    end

    // Full sequence, then DONE held and a second ireq ignored.
    trace("seq", 30, 1'b0, 1'b0);
    for (int k = 0; k < 100; k++) begin
      cyc();
      check("hold_fin", {31'd0, fin}, 32'h1);
    end
    ireq = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      ireq = 1'b0;
      check("req2_cmd", {28'd0, cs_n, ras_n, cas_n, we_n}, 32'h7);
      check("req2_cke_fin", {30'd0, cke, fin}, 32'h3);
    end

    // Bus released for the whole sequence; sequence still completes.
    do_reset();
    ienb = 1'b0;
    trace("hiz", 30, 1'b1, 1'b0);
    ienb = 1'b1;
    #1;
    check("hiz_after_cmd", {28'd0, cs_n, ras_n, cas_n, we_n}, 32'h7);
    check("hiz_after_cke_fin", {30'd0, cke, fin}, 32'h3);

    // Extra ireq pulses during WAIT change nothing.
    do_reset();
    trace("wreq", 30, 1'b0, 1'b1);

    // Reset during refresh aborts; reset beats a simultaneous ireq.
    do_reset();
    ireq = 1'b1;
    for (int k = 1; k <= 15; k++) begin
      cyc();
      ireq = 1'b0;
      if (k == 13) check("mid_aref", {28'd0, cs_n, ras_n, cas_n, we_n}, 32'h1);
    end
    ireset = 1'b0;
    cyc();
    check("abort_cke_fin", {30'd0, cke, fin}, 32'h0);
    check("abort_cmd", {28'd0, cs_n, ras_n, cas_n, we_n}, 32'h7);
    ireq = 1'b1;
    cyc();
    check("rst_wins_cke", {31'd0, cke}, 32'h0);
    ireq   = 1'b0;
    ireset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cyc();
      check("post_abort_idle", {30'd0, cke, fin}, 32'h0);
    end
    trace("restart", 30, 1'b0, 1'b0);

    // Default timing: 20000 + 1 + 3 + 8*7 + 2 = 20062 cycles to done.
    ireset2 = 1'b1;
    cyc();
    nref = 0; pre_k = -1; lmr_k = -1; fin_k = -1; dq_bad = 1'b0;
    ireq2 = 1'b1;
    for (int k = 1; k <= 20100; k++) begin
      cyc();
      ireq2 = 1'b0;
      if ({cs_n2, ras_n2, cas_n2, we_n2} == 4'b0001) nref++;
      if ({cs_n2, ras_n2, cas_n2, we_n2} == 4'b0010 && pre_k < 0) pre_k = k;
      if ({cs_n2, ras_n2, cas_n2, we_n2} == 4'b0000 && lmr_k < 0) lmr_k = k;
      if (fin2 && fin_k < 0) fin_k = k;
      if (dq2 !== 16'hFFFF) dq_bad = 1'b1;
      if (fin_k >= 0 && k > fin_k + 5) break;
    end
    check("def_nref", nref, 8);
    check("def_pre_cycle", pre_k, 20001);
    check("def_lmr_cycle", lmr_k, 20060);
    check("def_fin_cycle", fin_k, 20062);
    check("def_lmr_addr_seen", {31'd0, fin2}, 32'h1);
    check("def_dq_undriven", {31'd0, dq_bad}, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
